// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the shared memory port.
// The arbiter uses the slave modport; the requesters/memory model use master.
interface mem_port_arbiter_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        proto_err_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output proto_err_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  proto_err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between fetch and load/store, with in-order
// response steering through a source-ID FIFO and a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD_I = 2'd1, HOLD_D = 2'd2} state_e;

    state_e                     state_q, state_d;
    logic [3:0]                 starve_q, starve_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       proto_err_q, proto_err_d;

    logic sel_valid_s, sel_data_s, sel_ok_s, starve_hit_s;
    logic fifo_full_s, fifo_empty_s, mem_req_s, push_s, pop_s, head_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign starve_hit_s = (starve_q == 4'(STARVE_LIMIT));
    assign fifo_full_s  = (count_q == CW'(MAX_OUTSTANDING));
    assign fifo_empty_s = (count_q == {CW{1'b0}});
    assign head_s       = fifo_q[rd_ptr_q];

    // Source selection: a held requester keeps the port unless it withdraws its request.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = 1'b0;
        case (state_q)
            HOLD_I: begin
                if (bus.instr_req_i) begin
                    sel_valid_s = 1'b1;
                    sel_data_s  = 1'b0;
                end else begin
                    sel_valid_s = bus.data_req_i;
                    sel_data_s  = 1'b1;
                end
            end
            HOLD_D: begin
                if (bus.data_req_i) begin
                    sel_valid_s = 1'b1;
                    sel_data_s  = 1'b1;
                end else begin
                    sel_valid_s = bus.instr_req_i;
                    sel_data_s  = 1'b0;
                end
            end
            default: begin
                if (starve_hit_s && bus.instr_req_i) begin
                    sel_valid_s = 1'b1;
                    sel_data_s  = 1'b0;
                end else if (bus.data_req_i) begin
                    sel_valid_s = 1'b1;
                    sel_data_s  = 1'b1;
                end else if (bus.instr_req_i) begin
                    sel_valid_s = 1'b1;
                    sel_data_s  = 1'b0;
                end else begin
                    sel_valid_s = 1'b0;
                    sel_data_s  = 1'b0;
                end
            end
        endcase
    end

    assign sel_ok_s  = sel_valid_s && !rst;
    assign mem_req_s = sel_ok_s && !fifo_full_s;
    assign push_s    = mem_req_s && bus.mem_gnt_i;
    assign pop_s     = bus.mem_rvalid_i && !fifo_empty_s && !rst;

    // Next-state for the FSM, starvation counter, source FIFO and protocol-error flag.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        proto_err_d = proto_err_q | (bus.mem_rvalid_i && fifo_empty_s);

        if (mem_req_s) begin
            if (bus.mem_gnt_i) begin
                state_d = IDLE;
            end else begin
                state_d = sel_data_s ? HOLD_D : HOLD_I;
            end
        end else if (!fifo_full_s) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end

        if (!bus.instr_req_i || (push_s && !sel_data_s)) begin
            starve_d = 4'd0;
        end else if (push_s && !starve_hit_s) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        if (push_s) begin
            fifo_d[wr_ptr_q] = sel_data_s;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            fifo_q      <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Memory-side address phase driven by whichever source is selected; fetch is a full-word read.
    always_comb begin
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        bus.mem_addr_o  = 32'h0;
        bus.mem_wdata_o = 32'h0;
        if (sel_ok_s && sel_data_s) begin
            bus.mem_we_o    = bus.data_we_i;
            bus.mem_be_o    = bus.data_be_i;
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_wdata_o = bus.data_wdata_i;
        end else if (sel_ok_s) begin
            bus.mem_we_o    = 1'b0;
            bus.mem_be_o    = 4'hF;
            bus.mem_addr_o  = bus.instr_addr_i;
            bus.mem_wdata_o = 32'h0;
        end else begin
            bus.mem_we_o    = 1'b0;
        end
    end

    assign bus.mem_req_o      = mem_req_s;
    assign bus.instr_gnt_o    = push_s && !sel_data_s;
    assign bus.data_gnt_o     = push_s && sel_data_s;
    assign bus.instr_rvalid_o = pop_s && !head_s;
    assign bus.data_rvalid_o  = pop_s && head_s;
    assign bus.instr_rdata_o  = rst ? 32'h0 : bus.mem_rdata_i;
    assign bus.data_rdata_o   = rst ? 32'h0 : bus.mem_rdata_i;
    assign bus.instr_err_o    = bus.mem_err_i && !rst;
    assign bus.data_err_o     = bus.mem_err_i && !rst;
    assign bus.proto_err_o    = proto_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: arbitration order, hold/flush, FIFO limits,
// response routing, protocol error and asynchronous reset.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } resp_t;

    logic  exp_src_q[$];
    resp_t resp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle_inputs();
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = 32'h0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = 4'h0;
        bus.data_addr_i  = 32'h0;
        bus.data_wdata_i = 32'h0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        bus.mem_err_i    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        exp_src_q.delete();
        resp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.instr_req_i  = 1'b1;
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h1234_5678;
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEAD_BEEF;
        bus.mem_err_i    = 1'b1;
        #1;
        n_total++;
        if ({bus.instr_gnt_o, bus.instr_rvalid_o, bus.instr_err_o, bus.data_gnt_o, bus.data_rvalid_o,
             bus.data_err_o, bus.mem_req_o, bus.mem_we_o, bus.proto_err_o} !== 9'b0)
            $display("FAIL reset_ctrl: got %b want 0", {bus.instr_gnt_o, bus.instr_rvalid_o, bus.instr_err_o,
                     bus.data_gnt_o, bus.data_rvalid_o, bus.data_err_o, bus.mem_req_o, bus.mem_we_o, bus.proto_err_o});
        else n_pass++;
        n_total++;
        if ({bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o, bus.instr_rdata_o, bus.data_rdata_o} !== 132'h0)
            $display("FAIL reset_bus: got addr %h rdata %h want 0", bus.mem_addr_o, bus.instr_rdata_o);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_total++;
        if ({bus.mem_req_o, bus.proto_err_o} !== 2'b00)
            $display("FAIL reset_release: got %b want 00", {bus.mem_req_o, bus.proto_err_o});
        else n_pass++;
    endtask

    task automatic test_starvation();
        logic  e;
        resp_t r;
        do_reset();
        exp_src_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_1000;
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h0000_2000;
        bus.data_be_i    = 4'h3;
        bus.mem_gnt_i    = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            bus.mem_rvalid_i = (c > 0);
            bus.mem_rdata_i  = 32'hA000_0000 + 32'(c);
            if (c == 10) begin
                bus.instr_req_i = 1'b0;
                bus.data_req_i  = 1'b0;
            end
            #1;
            if (c > 0 && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                n_total++;
                if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== {!r.is_data, r.is_data})
                    $display("FAIL starve_route c%0d: got %b want %b", c,
                             {bus.instr_rvalid_o, bus.data_rvalid_o}, {!r.is_data, r.is_data});
                else n_pass++;
                n_total++;
                if ((r.is_data ? bus.data_rdata_o : bus.instr_rdata_o) !== r.rdata)
                    $display("FAIL starve_rdata c%0d: got %h want %h", c,
                             r.is_data ? bus.data_rdata_o : bus.instr_rdata_o, r.rdata);
                else n_pass++;
            end
            if (c < 10) begin
                e = exp_src_q.pop_front();
                n_total++;
                if ({bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o} !== {!e, e, (e ? 32'h0000_2000 : 32'h0000_1000)})
                    $display("FAIL starve_grant c%0d: got i%b d%b addr %h want i%b d%b", c,
                             bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o, !e, e);
                else n_pass++;
                resp_q.push_back('{is_data: e, rdata: 32'hA000_0000 + 32'(c + 1)});
            end else begin
                n_total++;
                if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b00)
                    $display("FAIL starve_nogrant: got %b want 00", {bus.instr_gnt_o, bus.data_gnt_o});
                else n_pass++;
            end
            next_cycle();
        end
        idle_inputs();
        n_total++;
        if (resp_q.size() != 0) $display("FAIL starve_drain: got %0d left want 0", resp_q.size());
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_3000;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                bus.data_req_i   = 1'b1;
                bus.data_addr_i  = 32'h0000_4000;
                bus.data_we_i    = 1'b1;
                bus.data_be_i    = 4'hC;
                bus.data_wdata_i = 32'h0000_0055;
            end
            #1;
            n_total++;
            if ({bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_3000})
                $display("FAIL hold_c%0d: got req%b ig%b dg%b we%b be%h addr %h want fetch held", c,
                         bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o);
            else n_pass++;
            next_cycle();
        end
        bus.mem_gnt_i = 1'b1;
        #1;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o} !== {1'b1, 1'b0, 32'h0000_3000})
            $display("FAIL hold_gnt: got ig%b dg%b addr %h want ig1 dg0 addr 00003000",
                     bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o);
        else n_pass++;
        next_cycle();
        #1;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}
            !== {1'b0, 1'b1, 1'b1, 4'hC, 32'h0000_4000, 32'h0000_0055})
            $display("FAIL hold_data: got ig%b dg%b we%b be%h addr %h wdata %h want data store",
                     bus.instr_gnt_o, bus.data_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        #1;
        n_total++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b10)
            $display("FAIL hold_resp0: got %b want 10", {bus.instr_rvalid_o, bus.data_rvalid_o});
        else n_pass++;
        next_cycle();
        #1;
        n_total++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b01)
            $display("FAIL hold_resp1: got %b want 01", {bus.instr_rvalid_o, bus.data_rvalid_o});
        else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        logic [3:0] exp_tab[10];
        do_reset();
        // {mem_rvalid_i driven, mem_req_o, data_gnt_o, data_rvalid_o} per cycle
        exp_tab = '{4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b1001,
                    4'b1111, 4'b0110, 4'b0000, 4'b1001, 4'b1001};
        bus.data_we_i   = 1'b1;
        bus.data_be_i   = 4'hF;
        bus.data_addr_i = 32'h0000_5000;
        bus.mem_gnt_i   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.data_req_i   = (c < 8);
            bus.mem_rvalid_i = exp_tab[c][3];
            #1;
            n_total++;
            if ({bus.mem_req_o, bus.data_gnt_o, bus.data_rvalid_o} !== exp_tab[c][2:0])
                $display("FAIL fifo_full_c%0d: got req%b gnt%b rv%b want %b", c,
                         bus.mem_req_o, bus.data_gnt_o, bus.data_rvalid_o, exp_tab[c][2:0]);
            else n_pass++;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_err_routing();
        do_reset();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_6000;
        bus.mem_gnt_i    = 1'b1;
        #1;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b10)
            $display("FAIL err_fetch_gnt: got %b want 10", {bus.instr_gnt_o, bus.data_gnt_o});
        else n_pass++;
        next_cycle();
        bus.instr_req_i = 1'b0;
        bus.data_req_i  = 1'b1;
        bus.data_we_i   = 1'b1;
        bus.data_be_i   = 4'hF;
        bus.data_addr_i = 32'h0000_6100;
        #1;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b01)
            $display("FAIL err_store_gnt: got %b want 01", {bus.instr_gnt_o, bus.data_gnt_o});
        else n_pass++;
        next_cycle();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_err_i    = 1'b1;
        bus.mem_rdata_i  = 32'h0000_0BAD;
        #1;
        n_total++;
        if ({bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.instr_rdata_o} !== {3'b110, 32'h0000_0BAD})
            $display("FAIL err_resp_fetch: got rv%b err%b drv%b rdata %h want 1 1 0 00000bad",
                     bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.instr_rdata_o);
        else n_pass++;
        next_cycle();
        bus.mem_err_i   = 1'b0;
        bus.mem_rdata_i = 32'h0000_600D;
        #1;
        n_total++;
        if ({bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o, bus.data_rdata_o} !== {3'b100, 32'h0000_600D})
            $display("FAIL err_resp_store: got rv%b err%b irv%b rdata %h want 1 0 0 0000600d",
                     bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o, bus.data_rdata_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_total++;
        if (bus.proto_err_o !== 1'b0) $display("FAIL err_proto: got %b want 0", bus.proto_err_o);
        else n_pass++;
    endtask

    task automatic test_proto_err();
        do_reset();
        bus.mem_rvalid_i = 1'b1;
        #1;
        n_total++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.proto_err_o} !== 3'b000)
            $display("FAIL proto_drop: got %b want 000", {bus.instr_rvalid_o, bus.data_rvalid_o, bus.proto_err_o});
        else n_pass++;
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        #1;
        n_total++;
        if (bus.proto_err_o !== 1'b1) $display("FAIL proto_sticky: got %b want 1", bus.proto_err_o);
        else n_pass++;
        next_cycle();
        bus.instr_req_i = 1'b1;
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h0000_9000;
        bus.mem_gnt_i   = 1'b1;
        #1;
        n_total++;
        if ({bus.data_gnt_o, bus.proto_err_o} !== 2'b11)
            $display("FAIL proto_traffic: got %b want 11", {bus.data_gnt_o, bus.proto_err_o});
        else n_pass++;
        next_cycle();
        bus.mem_rvalid_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o, bus.mem_req_o,
             bus.mem_addr_o, bus.data_rdata_o, bus.proto_err_o} !== 70'h0)
            $display("FAIL proto_async_rst: got req%b dg%b addr %h perr%b want all 0",
                     bus.mem_req_o, bus.data_gnt_o, bus.mem_addr_o, bus.proto_err_o);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        bus.instr_req_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++;
            if ({bus.mem_req_o, bus.data_gnt_o, bus.proto_err_o} !== ((c < 2) ? 3'b110 : 3'b000))
                $display("FAIL proto_post_rst_c%0d: got %b want %b", c,
                         {bus.mem_req_o, bus.data_gnt_o, bus.proto_err_o}, (c < 2) ? 3'b110 : 3'b000);
            else n_pass++;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_7000;
        #1;
        n_total++;
        if ({bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o} !== {3'b100, 32'h0000_7000})
            $display("FAIL flush_hold: got req%b ig%b dg%b addr %h want 1 0 0 00007000",
                     bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o);
        else n_pass++;
        next_cycle();
        bus.instr_req_i = 1'b0;
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h0000_8000;
        bus.mem_gnt_i   = 1'b1;
        #1;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o} !== {2'b01, 32'h0000_8000})
            $display("FAIL flush_rearb: got ig%b dg%b addr %h want 0 1 00008000",
                     bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_0088;
        #1;
        n_total++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.data_rdata_o} !== {2'b01, 32'h0000_0088})
            $display("FAIL flush_resp: got irv%b drv%b rdata %h want 0 1 00000088",
                     bus.instr_rvalid_o, bus.data_rvalid_o, bus.data_rdata_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_total++;
        if ({bus.mem_req_o, bus.proto_err_o} !== 2'b00)
            $display("FAIL flush_idle: got %b want 00", {bus.mem_req_o, bus.proto_err_o});
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        test_reset();
        test_starvation();
        test_hold();
        test_fifo_full();
        test_err_routing();
        test_proto_err();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
